twf_12_seq: RTL and testbench

TWF_12_SEQ -- requirements
Module: twf_12_seq

---
 rtl/twf_pkg.sv | 19 +
 rtl/twf_seq_dly.sv | 45 ++++
 rtl/twf_12_seq.sv | 142 ++++++++++++++
 tb/tb_twf_12_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/twf_pkg.sv
// Shared types and constants for the twiddle-index sequencer.
// The FSM state encoding and the twiddle fixed-point format live here.
package twf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } twf_state_e;

  localparam int TWF_FRAC_BITS = 7;
  localparam int STALL_CNT_W   = 16;

  // Saturating increment for the stall counter.
  function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/twf_seq_dly.sv
// LAT-stage valid/data delay line; data only moves with its valid so the
// output word holds whenever no valid emerges. Flush clears every valid bit.
module twf_seq_dly #(
  parameter int LAT       = 1,
  parameter int BIT_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_flush,
  input  logic                        i_vld,
  input  logic signed [BIT_WIDTH-1:0] i_dat,
  output logic                        o_vld,
  output logic signed [BIT_WIDTH-1:0] o_dat
);

  logic [LAT-1:0]              r_vld;
  logic signed [BIT_WIDTH-1:0] r_dat [LAT];

  // Shift valid and data through the stages.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_dat[0] <= i_dat;
      end
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign o_vld = r_vld[LAT-1];
  assign o_dat = r_dat[LAT-1];

endmodule

// File: rtl/twf_12_seq.sv
// Twiddle-index sequencer: walks the twiddle ROM once per frame, one index per
// accepted sample. Optional stall counter enabled by TWF_SEQ_STALL_CNT_EN.
module twf_12_seq
  import twf_pkg::*;
#(
  parameter int INDEX_WIDTH = 512,
  parameter int BIT_WIDTH   = 9,
  parameter int LAT         = 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              cont_mode,
  input  logic                              din_valid,
  output logic [$clog2(INDEX_WIDTH)-1:0]    twf_index,
  input  logic signed [BIT_WIDTH-1:0]       twf_in,
  output logic signed [BIT_WIDTH-1:0]       twf_re,
  output logic                              dout_valid,
  output logic                              busy,
  output logic                              frame_done,
`ifdef TWF_SEQ_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0]            stall_cnt,
`endif
  output logic [7:0]                        frame_cnt
);

  localparam int            IW       = $clog2(INDEX_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(INDEX_WIDTH - 1);

  twf_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_enter_done;
  logic          w_accept;
  logic          r_busy;
  logic          r_frame_done;
  logic [7:0]    r_frame_cnt;

  // Next-state and next-index decode; abort overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_enter_done = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_idx_nxt = '0;
          if (start) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (din_valid) begin
            if (r_idx == LAST_IDX) begin
              w_state_nxt  = ST_DONE;
              w_idx_nxt    = '0;
              w_enter_done = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IW'(1);
            end
          end else begin
            w_idx_nxt = r_idx;
          end
        end
        ST_DONE: begin
          w_idx_nxt = '0;
          if (cont_mode || start) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  assign w_accept = (r_state == ST_RUN) && din_valid && !abort;

  // State, index and frame bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_busy       <= (w_state_nxt == ST_RUN);
      r_frame_done <= w_enter_done;
      if (w_enter_done) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  twf_seq_dly #(
    .LAT       (LAT),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_dly (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (abort),
    .i_vld   (w_accept),
    .i_dat   (twf_in),
    .o_vld   (dout_valid),
    .o_dat   (twf_re)
  );

`ifdef TWF_SEQ_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Count RUN cycles without a sample; start or abort clears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= 16'd0;
    end else if (start || abort) begin
      r_stall_cnt <= 16'd0;
    end else if ((r_state == ST_RUN) && !din_valid) begin
      r_stall_cnt <= sat_inc16(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign twf_index  = r_idx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_twf_12_seq.sv
// Self-checking bench for twf_12_seq: a frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_twf_12_seq;

  localparam int N = 512;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start, abort, cont_mode, din_valid;
  logic [8:0]        twf_index;
  logic signed [8:0] twf_in, twf_re;
  logic              dout_valid, busy, frame_done;
  logic [7:0]        frame_cnt;
`ifdef TWF_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  twf_12_seq dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .cont_mode  (cont_mode),
    .din_valid  (din_valid),
    .twf_index  (twf_index),
    .twf_in     (twf_in),
    .twf_re     (twf_re),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef TWF_SEQ_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic int rom(input int i);
    if (i == 9) return 118;
    if (i == 13) return -49;
    return ((i * 53 + 7) % 256) - 128;
  endfunction

  always_comb twf_in = 9'(rom(int'(twf_index)));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, running flag, done gap, output sample.
  int m_pos = 0, m_frames = 0, m_re = 0;
  bit m_run = 0, m_gap = 0, m_vld = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pos = 0; m_frames = 0; m_re = 0;
      m_run = 0; m_gap = 0; m_vld = 0;
    end else begin
      m_vld = m_run && din_valid && !abort;
      if (m_vld) m_re = rom(m_pos);
      if (abort) begin
        m_run = 0; m_gap = 0; m_pos = 0;
      end else if (m_gap) begin
        m_gap = 0; m_run = cont_mode || start; m_pos = 0;
      end else if (m_run) begin
        if (din_valid) begin
          m_pos = (m_pos + 1) % N;
          if (m_pos == 0) begin
            m_run = 0; m_gap = 1; m_frames = (m_frames + 1) % 256;
          end
        end
      end else if (start) begin
        m_run = 1; m_pos = 0;
      end
    end
  end

  int prev_idx = 0, dv_cnt = 0, done_cnt = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("twf_index", int'(twf_index), m_pos);
    check("busy", int'(busy), int'(m_run));
    check("frame_done", int'(frame_done), int'(m_gap));
    check("frame_cnt", int'(frame_cnt), m_frames);
    check("dout_valid", int'(dout_valid), int'(m_vld));
    check("twf_re", int'(twf_re), m_re);
    if (frame_done) check("done_after_last_idx", prev_idx, N - 1);
    prev_idx = int'(twf_index);
    dv_cnt   += int'(dout_valid);
    done_cnt += int'(frame_done);
  end

  task automatic cyc(input bit dv, input bit st, input bit ab, input bit cm);
    din_valid = dv; start = st; abort = ab; cont_mode = cm;
    @(posedge clk);
    #1;
  endtask

  int dv0, dn0;

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_index", int'(twf_index), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_fcnt", int'(frame_cnt), 0);
    check("rst_dv", int'(dout_valid), 0);
    check("rst_re", int'(twf_re), 0);
    rstn = 1'b1;
    cyc(0, 0, 0, 0);

    // One full frame.
    dv0 = dv_cnt; dn0 = done_cnt;
    cyc(0, 1, 0, 0);
    check("t1_busy", int'(busy), 1);
    for (int i = 0; i < N; i++) cyc(1, 0, 0, 0);
    check("t1_done", int'(frame_done), 1);
    check("t1_fcnt", int'(frame_cnt), 1);
    cyc(0, 0, 0, 0);
    check("t1_idle", int'(busy), 0);
    check("t1_dv_count", dv_cnt - dv0, 512);
    check("t1_done_count", done_cnt - dn0, 1);

    // ROM alignment, stall, abort.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    check("t2_idx9", int'(twf_index), 9);
    cyc(1, 0, 0, 0);
    check("t2_re118", int'(twf_re), 118);
    check("t2_dv", int'(dout_valid), 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("t2_re_m49", int'(twf_re), -49);
    for (int i = 0; i < 86; i++) cyc(1, 0, 0, 0);
    check("t3_idx100", int'(twf_index), 100);
    dv0 = dv_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      check("t3_hold", int'(twf_index), 100);
    end
    check("t3_no_dv", dv_cnt - dv0, 1);
`ifdef TWF_SEQ_STALL_CNT_EN
    check("t3_stall_cnt", int'(stall_cnt), 10);
`endif
    for (int i = 0; i < 200; i++) cyc(1, 0, 0, 0);
    check("t4_idx300", int'(twf_index), 300);
    cyc(1, 1, 1, 0);
    check("t4_abort_idx", int'(twf_index), 0);
    check("t4_abort_busy", int'(busy), 0);
    check("t4_abort_dv", int'(dout_valid), 0);
    check("t4_abort_fcnt", int'(frame_cnt), 1);

    // Continuous mode over three frames (frame_cnt 1 -> 4).
    dv0 = dv_cnt; dn0 = done_cnt;
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 3 * N + 2; i++) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t5_done_pulses", done_cnt - dn0, 3);
    check("t5_fcnt", int'(frame_cnt), 4);
    check("t5_dv_count", dv_cnt - dv0, 3 * N);
    check("t5_idle", int'(busy), 0);

    // Reset mid-frame.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 200; i++) cyc(1, 0, 0, 0);
    check("t6_idx200", int'(twf_index), 200);
    rstn = 1'b0;
    #1;
    check("t6_rst_idx", int'(twf_index), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_fcnt", int'(frame_cnt), 0);
    check("t6_rst_re", int'(twf_re), 0);
    check("t6_rst_dv", int'(dout_valid), 0);
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0);
    rstn = 1'b1;
    dn0 = done_cnt;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    check("t6_post_busy", int'(busy), 0);
    check("t6_post_idx", int'(twf_index), 0);
    check("t6_no_partial_done", done_cnt - dn0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("t6_restart_idx", int'(twf_index), 1);
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
